rl_ram_1r1w_arb: RTL and testbench
==================================

RL_RAM_1R1W_ARB -- requirements
Module: rl_ram_1r1w_arb

Interface
REQ-001 SHALL have parameter ABITS, default 10, RAM address width in bits.
REQ-002 SHALL have parameter DBITS, default 32, RAM data width in bits; BE = (DBITS+7)/8.
REQ-003 SHALL have port clk_i  in  1  single clock, rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, asynchronous, active-high.
REQ-005 SHALL have port wreq_i  in  2  write request, bit n = write client n.
REQ-006 SHALL have port waddr_i  in  2*ABITS  write address; client n at [n*ABITS +: ABITS].
REQ-007 SHALL have port wdata_i  in  2*DBITS  write data, packed per client.
REQ-008 SHALL have port wbe_i  in  2*BE  write byte enables, packed per client.
REQ-009 SHALL have port wgnt_o  out  2  write grant, one-hot or zero.
REQ-010 SHALL have port rreq_i  in  2  read request, bit n = read client n.
REQ-011 SHALL have port raddr_i  in  2*ABITS  read address, packed per client.
REQ-012 SHALL have port rgnt_o  out  2  read grant, one-hot or zero.
REQ-013 SHALL have port rvalid_o  out  2  read data valid, one-hot or zero.
REQ-014 SHALL have port rdata_o  out  DBITS  read data, shared by both read clients.
REQ-015 SHALL have ports ram_waddr_o/ram_din_o/ram_we_o/ram_be_o  out  ABITS/DBITS/1/BE  RAM write side.
REQ-016 SHALL have ports ram_raddr_o  out  ABITS and ram_dout_i  in  DBITS  RAM read side; RAM read latency is 1 cycle.

Function
REQ-017 Write and read sides SHALL be arbitrated independently, each by its own 1-bit round-robin pointer.
REQ-018 Grants SHALL be combinational in the request cycle: one requester -> granted; both -> the client the pointer selects.
REQ-019 After any grant, that side's pointer SHALL move to the other client on the next edge; with no grant, the pointer SHALL hold.
REQ-020 A request SHALL be consumed by the grant; a client SHALL hold req and payload stable until granted, and the arbiter SHALL NOT register requests.
REQ-021 ram_we_o SHALL equal |wgnt_o; ram_waddr_o/ram_din_o/ram_be_o SHALL mux the granted client's payload, and are don't-care (client 0 muxed) when ram_we_o=0.
REQ-022 ram_raddr_o SHALL mux the granted read client's address (client 0 when idle).
REQ-023 rvalid_o[n] SHALL assert exactly one cycle after rgnt_o[n], for one cycle; back-to-back grants SHALL give back-to-back rvalid.
REQ-024 Collision bypass: if the write and the read granted in the same cycle use the same address, the next-cycle rdata_o SHALL take wdata bytes where wbe=1 and ram_dout_i bytes elsewhere.
REQ-025 Otherwise rdata_o SHALL equal ram_dout_i; rdata_o is don't-care when rvalid_o=0.
REQ-026 Bypass state (hit flag, DBITS data, BE mask) SHALL be registered in the grant cycle and used only in the return cycle.
REQ-027 Under continuous requests from both clients, each SHALL be granted every second cycle; no starvation.

Reset
REQ-028 While rst_i=1: both pointers SHALL select client 0, rvalid_o=0, and bypass hit flag=0; grant outputs stay combinational from requests.
REQ-029 A read granted in the cycle rst_i asserts SHALL produce no rvalid_o; the first grant after release SHALL use pointer=0.

Verification
REQ-030 Reset, then wreq_i=2'b11 for 4 cycles -> wgnt_o = 01,10,01,10; ram_we_o=1 each cycle.
REQ-031 rreq_i=2'b10, raddr client1=0x05, RAM word 0x05=0xDEADBEEF -> rgnt_o=10 in cycle T, rvalid_o=10 and rdata_o=0xDEADBEEF in T+1.
REQ-032 Same cycle: write addr 0x10, data 0x11223344, be=4'b0101; read addr 0x10, old word 0xAABBCCDD -> rdata_o=0xAA22CC44 next cycle.
REQ-033 Same cycle: write addr 0x10, read addr 0x11 -> rdata_o=ram_dout_i unmodified.
REQ-034 rreq_i=2'b01 with grant in cycle T, rst_i asserted in T -> rvalid_o=00 in T+1; after release, rreq_i=2'b11 -> rgnt_o=01.
REQ-035 Random both-side traffic 10k cycles vs reference memory model -> all read data matches, grants one-hot, each rvalid one cycle after its grant.

Source files
------------

// File: rtl/rl_ram_1r1w_arb.sv
// rl_ram_1r1w_arb: two-client write / two-client read round-robin arbiter in front of a 1R1W RAM
//    clk_i, rst_i                        clock, async active-high reset
//    wreq_i/waddr_i/wdata_i/wbe_i        packed write requests from clients 0 and 1
//    wgnt_o                              combinational write grant, one-hot or zero
//    rreq_i/raddr_i                      packed read requests from clients 0 and 1
//    rgnt_o, rvalid_o, rdata_o           read grant, read data valid one cycle later, shared read data
//    ram_waddr_o/ram_din_o/ram_we_o/ram_be_o, ram_raddr_o, ram_dout_i   RAM ports (1-cycle read)
module rl_ram_1r1w_arb #(
   parameter int ABITS = 10,
   parameter int DBITS = 32,
   localparam int BE = (DBITS + 7) / 8
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic [1:0]         wreq_i,
   input  logic [2*ABITS-1:0] waddr_i,
   input  logic [2*DBITS-1:0] wdata_i,
   input  logic [2*BE-1:0]    wbe_i,
   output logic [1:0]         wgnt_o,
   input  logic [1:0]         rreq_i,
   input  logic [2*ABITS-1:0] raddr_i,
   output logic [1:0]         rgnt_o,
   output logic [1:0]         rvalid_o,
   output logic [DBITS-1:0]   rdata_o,
   output logic [ABITS-1:0]   ram_waddr_o,
   output logic [DBITS-1:0]   ram_din_o,
   output logic               ram_we_o,
   output logic [BE-1:0]      ram_be_o,
   output logic [ABITS-1:0]   ram_raddr_o,
   input  logic [DBITS-1:0]   ram_dout_i
);
   logic             wptr_q, wptr_d, rptr_q, rptr_d, hit_q, hit_d;
   logic [1:0]       rvalid_q;
   logic [DBITS-1:0] bdata_q;
   logic [BE-1:0]    bmask_q;
   always_comb begin
      wgnt_o      = &wreq_i ? {wptr_q, ~wptr_q} : wreq_i;
      rgnt_o      = &rreq_i ? {rptr_q, ~rptr_q} : rreq_i;
      // after a grant the pointer favours the client that was not served
      wptr_d      = |wgnt_o ? wgnt_o[0] : wptr_q;
      rptr_d      = |rgnt_o ? rgnt_o[0] : rptr_q;
      ram_we_o    = |wgnt_o;
      ram_waddr_o = wgnt_o[1] ? waddr_i[ABITS +: ABITS] : waddr_i[0 +: ABITS];
      ram_din_o   = wgnt_o[1] ? wdata_i[DBITS +: DBITS] : wdata_i[0 +: DBITS];
      ram_be_o    = wgnt_o[1] ? wbe_i[BE +: BE] : wbe_i[0 +: BE];
      ram_raddr_o = rgnt_o[1] ? raddr_i[ABITS +: ABITS] : raddr_i[0 +: ABITS];
      // the RAM returns the old word on a same-address collision, so remember the write
      hit_d       = ram_we_o && (|rgnt_o) && (ram_waddr_o == ram_raddr_o);
   end
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wptr_q   <= 1'b0;
         rptr_q   <= 1'b0;
         hit_q    <= 1'b0;
         rvalid_q <= 2'b00;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         hit_q    <= hit_d;
         rvalid_q <= rgnt_o;
      end
   end
   always_ff @(posedge clk_i) begin
      bdata_q <= ram_din_o;
      bmask_q <= ram_be_o;
   end
   assign rvalid_o = rvalid_q;
   for (genvar i = 0; i < DBITS; i++) begin : g_byp
      assign rdata_o[i] = (hit_q && bmask_q[i/8]) ? bdata_q[i] : ram_dout_i[i];
   end
endmodule

// File: tb/tb_rl_ram_1r1w_arb.sv
// tb_rl_ram_1r1w_arb: directed and random checks of rl_ram_1r1w_arb against an external RAM model
module tb_rl_ram_1r1w_arb;
   logic        clk, rst;
   logic [1:0]  wreq, wgnt, rreq, rgnt, rvalid;
   logic [19:0] waddr, raddr;
   logic [63:0] wdata;
   logic [7:0]  wbe;
   logic [31:0] rdata, ram_din, ram_dout;
   logic [9:0]  ram_waddr, ram_raddr;
   logic        ram_we;
   logic [3:0]  ram_be;
   logic [31:0] mem  [0:1023];
   logic [31:0] rmem [0:1023];
   int n_checks, n_fail;

   rl_ram_1r1w_arb dut (
      .clk_i(clk), .rst_i(rst),
      .wreq_i(wreq), .waddr_i(waddr), .wdata_i(wdata), .wbe_i(wbe), .wgnt_o(wgnt),
      .rreq_i(rreq), .raddr_i(raddr), .rgnt_o(rgnt), .rvalid_o(rvalid), .rdata_o(rdata),
      .ram_waddr_o(ram_waddr), .ram_din_o(ram_din), .ram_we_o(ram_we), .ram_be_o(ram_be),
      .ram_raddr_o(ram_raddr), .ram_dout_i(ram_dout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // read-first RAM, one cycle read latency
   always @(posedge clk) begin
      ram_dout <= mem[ram_raddr];
      if (ram_we)
         for (int b = 0; b < 4; b++)
            if (ram_be[b]) mem[ram_waddr][b*8 +: 8] = ram_din[b*8 +: 8];
   end

   function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
      for (int b = 0; b < 4; b++)
         if (be[b]) o[b*8 +: 8] = n[b*8 +: 8];
      return o;
   endfunction

   task automatic step;
      @(posedge clk);
      #1;
   endtask

   task automatic idle;
      wreq = 2'b00; rreq = 2'b00;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      step();
      step();
      wreq = 2'b11; rreq = 2'b11;
      #1;
      n_checks++; if (wgnt !== 2'b01) begin n_fail++; $display("FAIL reset_wgnt got %b exp 01", wgnt); end
      n_checks++; if (rgnt !== 2'b01) begin n_fail++; $display("FAIL reset_rgnt got %b exp 01", rgnt); end
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid got %b exp 00", rvalid); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL reset_rvalid_after_grant got %b exp 00", rvalid); end
      rst = 1'b0;
   endtask

   task automatic test_write_rr;
      logic [1:0] exp;
      wreq = 2'b11; waddr = {10'h2, 10'h1}; wdata = {32'hB1B1B1B1, 32'hA0A0A0A0}; wbe = 8'hFF;
      for (int i = 0; i < 4; i++) begin
         exp = (i % 2 == 0) ? 2'b01 : 2'b10;
         #1;
         n_checks++; if (wgnt !== exp) begin n_fail++; $display("FAIL wr_rr_gnt[%0d] got %b exp %b", i, wgnt, exp); end
         n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL wr_rr_we[%0d] got %b exp 1", i, ram_we); end
         n_checks++; if (ram_waddr !== (exp[1] ? 10'h2 : 10'h1)) begin n_fail++; $display("FAIL wr_rr_addr[%0d] got %h", i, ram_waddr); end
         n_checks++; if (ram_din !== (exp[1] ? 32'hB1B1B1B1 : 32'hA0A0A0A0)) begin n_fail++; $display("FAIL wr_rr_din[%0d] got %h", i, ram_din); end
         step();
      end
      idle();
      #1;
      n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL wr_idle_we got %b exp 0", ram_we); end
      n_checks++; if (mem[2] !== 32'hB1B1B1B1) begin n_fail++; $display("FAIL wr_rr_mem2 got %h exp b1b1b1b1", mem[2]); end
   endtask

   task automatic test_read;
      mem[5] = 32'hDEADBEEF;
      rreq = 2'b10; raddr = {10'h5, 10'h3FF};
      #1;
      n_checks++; if (rgnt !== 2'b10) begin n_fail++; $display("FAIL rd_gnt got %b exp 10", rgnt); end
      n_checks++; if (ram_raddr !== 10'h5) begin n_fail++; $display("FAIL rd_raddr got %h exp 005", ram_raddr); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b10) begin n_fail++; $display("FAIL rd_valid got %b exp 10", rvalid); end
      n_checks++; if (rdata !== 32'hDEADBEEF) begin n_fail++; $display("FAIL rd_data got %h exp deadbeef", rdata); end
      step();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rd_valid_single got %b exp 00", rvalid); end
   endtask

   task automatic test_back_to_back;
      mem[3] = 32'h33333333; mem[4] = 32'h44444444;
      raddr = {10'h4, 10'h3};
      rreq = 2'b01;
      step();
      rreq = 2'b10;
      n_checks++; if (rvalid !== 2'b01 || rdata !== 32'h33333333) begin n_fail++; $display("FAIL b2b_first got %b/%h exp 01/33333333", rvalid, rdata); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b10 || rdata !== 32'h44444444) begin n_fail++; $display("FAIL b2b_second got %b/%h exp 10/44444444", rvalid, rdata); end
      step();
   endtask

   task automatic test_bypass;
      mem[16] = 32'hAABBCCDD;
      wreq = 2'b01; waddr = {10'h0, 10'h10}; wdata = {32'h0, 32'h11223344}; wbe = {4'h0, 4'b0101};
      rreq = 2'b01; raddr = {10'h0, 10'h10};
      #1;
      n_checks++; if (ram_be !== 4'b0101) begin n_fail++; $display("FAIL byp_be got %b exp 0101", ram_be); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b01 || rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL byp_data got %b/%h exp 01/aa22cc44", rvalid, rdata); end
      rreq = 2'b01;
      step();
      idle();
      n_checks++; if (rdata !== 32'hAA22CC44) begin n_fail++; $display("FAIL byp_stored got %h exp aa22cc44", rdata); end
      step();
   endtask

   task automatic test_no_bypass;
      mem[16] = 32'h01010101; mem[17] = 32'h55667788;
      wreq = 2'b01; waddr = {10'h0, 10'h10}; wdata = {32'h0, 32'hFFFFFFFF}; wbe = 8'hFF;
      rreq = 2'b10; raddr = {10'h11, 10'h10};
      step();
      idle();
      n_checks++; if (rvalid !== 2'b10 || rdata !== 32'h55667788) begin n_fail++; $display("FAIL nobyp_data got %b/%h exp 10/55667788", rvalid, rdata); end
      step();
   endtask

   task automatic test_reset_read;
      raddr = {10'h4, 10'h3};
      rreq = 2'b01;
      step();
      rreq = 2'b01; rst = 1'b1;
      #1;
      n_checks++; if (rgnt !== 2'b01) begin n_fail++; $display("FAIL rstrd_gnt got %b exp 01", rgnt); end
      step();
      idle();
      n_checks++; if (rvalid !== 2'b00) begin n_fail++; $display("FAIL rstrd_valid got %b exp 00", rvalid); end
      rst = 1'b0; rreq = 2'b11;
      #1;
      n_checks++; if (rgnt !== 2'b01) begin n_fail++; $display("FAIL rstrd_first_gnt got %b exp 01", rgnt); end
      step();
      idle();
      step();
   endtask

   task automatic test_random;
      logic       ewp, erp;
      logic [1:0] ew, er;
      logic [9:0] wa, ra;
      logic [31:0] wd, pend;
      logic [3:0] wb;
      int errs;
      errs = 0;
      rst = 1'b1;
      for (int i = 0; i < 1024; i++) begin mem[i] = 32'h9E3779B9 * i; rmem[i] = 32'h9E3779B9 * i; end
      step();
      rst = 1'b0;
      ewp = 1'b0; erp = 1'b0; pend = '0;
      for (int c = 0; c < 10000; c++) begin
         wreq  = 2'($urandom_range(0, 3));
         rreq  = 2'($urandom_range(0, 3));
         waddr = {10'($urandom_range(0, 7)), 10'($urandom_range(0, 7))};
         raddr = {10'($urandom_range(0, 7)), 10'($urandom_range(0, 7))};
         wdata = {$urandom, $urandom};
         wbe   = 8'($urandom);
         #1;
         ew = &wreq ? (ewp ? 2'b10 : 2'b01) : wreq;
         er = &rreq ? (erp ? 2'b10 : 2'b01) : rreq;
         n_checks++; if (wgnt !== ew || ram_we !== |ew) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_wgnt c%0d got %b exp %b", c, wgnt, ew); end
         n_checks++; if (rgnt !== er) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_rgnt c%0d got %b exp %b", c, rgnt, er); end
         wa = ew[1] ? waddr[19:10] : waddr[9:0];
         wd = ew[1] ? wdata[63:32] : wdata[31:0];
         wb = ew[1] ? wbe[7:4] : wbe[3:0];
         ra = er[1] ? raddr[19:10] : raddr[9:0];
         if (|er) pend = (|ew && wa == ra) ? merge(rmem[ra], wd, wb) : rmem[ra];
         if (|ew) rmem[wa] = merge(rmem[wa], wd, wb);
         if (|ew) ewp = ew[0];
         if (|er) erp = er[0];
         step();
         n_checks++; if (rvalid !== er) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_rvalid c%0d got %b exp %b", c, rvalid, er); end
         if (|er) begin
            n_checks++; if (rdata !== pend) begin n_fail++; errs++; if (errs < 10) $display("FAIL rnd_rdata c%0d got %h exp %h", c, rdata, pend); end
         end
      end
      idle();
   endtask

   initial begin
      n_checks = 0; n_fail = 0;
      rst = 1'b1; idle();
      waddr = '0; raddr = '0; wdata = '0; wbe = '0;
      for (int i = 0; i < 1024; i++) mem[i] = '0;
      test_reset();
      test_write_rr();
      test_read();
      test_back_to_back();
      test_bypass();
      test_no_bypass();
      test_reset_read();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
